// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Resolves decoder source operands from the registers, a commit bypass, or the ROB.
module reg_status_file #(
    parameter int ROB_BIT = 3,
    parameter int REG_NUM = 32
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               clear_up,
    input  logic               issue_valid,
    input  logic [4:0]         issue_rd,
    input  logic [ROB_BIT-1:0] issue_rob_entry,
    input  logic               commit_valid,
    input  logic [4:0]         commit_rd,
    input  logic [ROB_BIT-1:0] commit_rob_entry,
    input  logic [31:0]        commit_value,
    input  logic [4:0]         rs1_id,
    input  logic [4:0]         rs2_id,
    output logic               op1_ready,
    output logic [31:0]        op1_value,
    output logic [ROB_BIT-1:0] op1_tag,
    output logic               op2_ready,
    output logic [31:0]        op2_value,
    output logic [ROB_BIT-1:0] op2_tag,
    output logic [ROB_BIT-1:0] get_rob_entry1,
    output logic [ROB_BIT-1:0] get_rob_entry2,
    input  logic               ready1,
    input  logic [31:0]        value1,
    input  logic               ready2,
    input  logic [31:0]        value2
);

    logic [31:0]        regs_q [REG_NUM];
    logic [31:0]        regs_d [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;
    logic [ROB_BIT-1:0] tag_q  [REG_NUM];
    logic [ROB_BIT-1:0] tag_d  [REG_NUM];

    // Returns {ready, value}; lookup always uses the pre-issue state of the register.
    function automatic logic [32:0] resolve(
        input logic [4:0]         s,
        input logic               busy_s,
        input logic [ROB_BIT-1:0] tag_s,
        input logic [31:0]        reg_s,
        input logic               cm_valid,
        input logic [4:0]         cm_rd,
        input logic [ROB_BIT-1:0] cm_entry,
        input logic [31:0]        cm_value,
        input logic               rob_ready,
        input logic [31:0]        rob_value
    );
        if (s == 5'd0)
            return {1'b1, 32'd0};
        if (!busy_s)
            return {1'b1, reg_s};
        if (cm_valid && cm_rd == s && tag_s == cm_entry)
            return {1'b1, cm_value};
        if (rob_ready)
            return {1'b1, rob_value};
        return {1'b0, 32'd0};
    endfunction

    always_comb begin
        {op1_ready, op1_value} = resolve(rs1_id, busy_q[rs1_id], tag_q[rs1_id], regs_q[rs1_id],
                                         commit_valid, commit_rd, commit_rob_entry, commit_value,
                                         ready1, value1);
        {op2_ready, op2_value} = resolve(rs2_id, busy_q[rs2_id], tag_q[rs2_id], regs_q[rs2_id],
                                         commit_valid, commit_rd, commit_rob_entry, commit_value,
                                         ready2, value2);
        op1_tag        = tag_q[rs1_id];
        op2_tag        = tag_q[rs2_id];
        get_rob_entry1 = tag_q[rs1_id];
        get_rob_entry2 = tag_q[rs2_id];
    end

    // Commit is applied first so a same-cycle issue to the same register wins busy/tag.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy_in) begin
            if (commit_valid && commit_rd != 5'd0) begin
                regs_d[commit_rd] = commit_value;
                if (tag_q[commit_rd] == commit_rob_entry)
                    busy_d[commit_rd] = 1'b0;
            end
            if (clear_up) begin
                busy_d = '0;
                for (int i = 0; i < REG_NUM; i++)
                    tag_d[i] = '0;
            end else if (issue_valid && issue_rd != 5'd0) begin
                busy_d[issue_rd] = 1'b1;
                tag_d[issue_rd]  = issue_rob_entry;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios plus randomized traffic
// compared against an array-based model of the register/rename state.
module tb_reg_status_file;
    localparam int RB = 3;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          rdy_in = 1'b1;
    logic          clear_up = 1'b0;
    logic          issue_valid = 1'b0;
    logic [4:0]    issue_rd = '0;
    logic [RB-1:0] issue_rob_entry = '0;
    logic          commit_valid = 1'b0;
    logic [4:0]    commit_rd = '0;
    logic [RB-1:0] commit_rob_entry = '0;
    logic [31:0]   commit_value = '0;
    logic [4:0]    rs1_id = '0;
    logic [4:0]    rs2_id = '0;
    logic          ready1 = 1'b0;
    logic [31:0]   value1 = '0;
    logic          ready2 = 1'b0;
    logic [31:0]   value2 = '0;
    logic          op1_ready, op2_ready;
    logic [31:0]   op1_value, op2_value;
    logic [RB-1:0] op1_tag, op2_tag, get_rob_entry1, get_rob_entry2;

    int checks = 0;
    int errors = 0;

    logic [31:0]   m_regs [32];
    logic          m_busy [32];
    logic [RB-1:0] m_tag  [32];

    reg_status_file #(.ROB_BIT(RB), .REG_NUM(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_up(clear_up),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_entry(issue_rob_entry),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_rob_entry(commit_rob_entry), .commit_value(commit_value),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .op1_ready(op1_ready), .op1_value(op1_value), .op1_tag(op1_tag),
        .op2_ready(op2_ready), .op2_value(op2_value), .op2_tag(op2_tag),
        .get_rob_entry1(get_rob_entry1), .get_rob_entry2(get_rob_entry2),
        .ready1(ready1), .value1(value1), .ready2(ready2), .value2(value2)
    );

    always #5 clk_in = ~clk_in;

    // Expected {ready, value} for a source, following the operand priority rules.
    function automatic logic [32:0] exp_op(input logic [4:0] s, input logic rk, input logic [31:0] vk);
        if (s == 0) return {1'b1, 32'd0};
        if (!m_busy[s]) return {1'b1, m_regs[s]};
        if (commit_valid && commit_rd == s && m_tag[s] == commit_rob_entry) return {1'b1, commit_value};
        if (rk) return {1'b1, vk};
        return {1'b0, 32'd0};
    endfunction

    task automatic idle();
        rdy_in = 1'b1; clear_up = 1'b0; issue_valid = 1'b0; commit_valid = 1'b0;
        ready1 = 1'b0; ready2 = 1'b0; value1 = '0; value2 = '0;
    endtask

    // Advance the model with the currently driven inputs, then clock the DUT.
    task automatic tick();
        if (rdy_in) begin
            if (commit_valid && commit_rd != 0) begin
                m_regs[commit_rd] = commit_value;
                if (m_tag[commit_rd] == commit_rob_entry) m_busy[commit_rd] = 1'b0;
            end
            if (clear_up) begin
                for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
            end else if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                m_tag[issue_rd]  = issue_rob_entry;
            end
        end
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic [RB-1:0] tg);
        idle(); issue_valid = 1'b1; issue_rd = rd; issue_rob_entry = tg; tick(); idle();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [RB-1:0] e, input logic [31:0] v);
        idle(); commit_valid = 1'b1; commit_rd = rd; commit_rob_entry = e; commit_value = v; tick(); idle();
    endtask

    task automatic test_reset();
        #2 rst_in = 1'b0;
        for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0; end
        idle();
        @(posedge clk_in); @(posedge clk_in); #1;
        for (int i = 0; i < 32; i++) begin
            rs1_id = 5'(i); rs2_id = 5'(31 - i); #1;
            checks++;
            if ({op1_ready, op1_value, op1_tag, get_rob_entry1} !== {1'b1, 32'd0, 3'd0, 3'd0}) begin
                errors++; $display("FAIL reset_op1 r%0d: got rdy=%b val=%h tag=%0d get=%0d, want 1/0/0/0",
                                   i, op1_ready, op1_value, op1_tag, get_rob_entry1);
            end
            checks++;
            if ({op2_ready, op2_value, op2_tag, get_rob_entry2} !== {1'b1, 32'd0, 3'd0, 3'd0}) begin
                errors++; $display("FAIL reset_op2 r%0d: got rdy=%b val=%h tag=%0d get=%0d, want 1/0/0/0",
                                   31 - i, op2_ready, op2_value, op2_tag, get_rob_entry2);
            end
        end
        @(negedge clk_in) rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_x0();
        idle(); commit_valid = 1'b1; commit_rd = 5'd0; commit_rob_entry = '0; commit_value = 32'd5;
        issue_valid = 1'b1; issue_rd = 5'd0; issue_rob_entry = 3'd3;
        tick(); idle();
        rs1_id = 5'd0; ready1 = 1'b1; value1 = 32'hDEAD; #1;
        checks++;
        if ({op1_ready, op1_value, get_rob_entry1} !== {1'b1, 32'd0, 3'd0}) begin
            errors++; $display("FAIL x0_read: got rdy=%b val=%h get=%0d, want 1/0/0", op1_ready, op1_value, get_rob_entry1);
        end
        idle();
    endtask

    task automatic test_rob_forward();
        do_issue(5'd5, 3'd3);
        rs1_id = 5'd5; rs2_id = 5'd5; #1;
        checks++;
        if ({op1_ready, op1_value, op1_tag, get_rob_entry1} !== {1'b0, 32'd0, 3'd3, 3'd3}) begin
            errors++; $display("FAIL fwd_wait: got rdy=%b val=%h tag=%0d get=%0d, want 0/0/3/3",
                               op1_ready, op1_value, op1_tag, get_rob_entry1);
        end
        checks++;
        if ({op2_ready, op2_tag, get_rob_entry2} !== {1'b0, 3'd3, 3'd3}) begin
            errors++; $display("FAIL fwd_wait2: got rdy=%b tag=%0d get=%0d, want 0/3/3", op2_ready, op2_tag, get_rob_entry2);
        end
        ready1 = 1'b1; value1 = 32'h1234; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'h1234}) begin
            errors++; $display("FAIL fwd_rob: got rdy=%b val=%h, want 1/00001234", op1_ready, op1_value);
        end
        do_commit(5'd5, 3'd3, 32'h55);
        rs1_id = 5'd5; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'h55}) begin
            errors++; $display("FAIL fwd_commit: got rdy=%b val=%h, want 1/00000055", op1_ready, op1_value);
        end
    endtask

    task automatic test_younger_rename();
        do_issue(5'd5, 3'd2);
        do_issue(5'd5, 3'd4);
        do_commit(5'd5, 3'd2, 32'd7);
        rs1_id = 5'd5; #1;
        checks++;
        if ({op1_ready, op1_tag, get_rob_entry1} !== {1'b0, 3'd4, 3'd4}) begin
            errors++; $display("FAIL young_busy: got rdy=%b tag=%0d get=%0d, want 0/4/4", op1_ready, op1_tag, get_rob_entry1);
        end
        // Flush exposes the architectural value left by the older commit.
        idle(); clear_up = 1'b1; tick(); idle();
        rs1_id = 5'd5; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'd7}) begin
            errors++; $display("FAIL young_value: got rdy=%b val=%h, want 1/00000007", op1_ready, op1_value);
        end
    endtask

    task automatic test_commit_bypass();
        do_issue(5'd6, 3'd1);
        commit_valid = 1'b1; commit_rd = 5'd6; commit_rob_entry = 3'd1; commit_value = 32'd9;
        rs2_id = 5'd6; ready2 = 1'b0; #1;
        checks++;
        if ({op2_ready, op2_value} !== {1'b1, 32'd9}) begin
            errors++; $display("FAIL bypass_same: got rdy=%b val=%h, want 1/00000009", op2_ready, op2_value);
        end
        tick(); idle();
        rs2_id = 5'd6; #1;
        checks++;
        if ({op2_ready, op2_value} !== {1'b1, 32'd9}) begin
            errors++; $display("FAIL bypass_next: got rdy=%b val=%h, want 1/00000009", op2_ready, op2_value);
        end
    endtask

    task automatic test_issue_commit_same();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7; issue_rob_entry = 3'd5;
        commit_valid = 1'b1; commit_rd = 5'd7; commit_rob_entry = 3'd0; commit_value = 32'hAA;
        rs1_id = 5'd7; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL same_pre_issue: got rdy=%b val=%h, want 1/00000000", op1_ready, op1_value);
        end
        tick(); idle();
        rs1_id = 5'd7; #1;
        checks++;
        if ({op1_ready, op1_tag} !== {1'b0, 3'd5}) begin
            errors++; $display("FAIL same_issue_wins: got rdy=%b tag=%0d, want 0/5", op1_ready, op1_tag);
        end
        idle(); clear_up = 1'b1; tick(); idle();
        rs1_id = 5'd7; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'hAA}) begin
            errors++; $display("FAIL same_value: got rdy=%b val=%h, want 1/000000aa", op1_ready, op1_value);
        end
    endtask

    task automatic test_clear();
        do_commit(5'd4, 3'd0, 32'h44);
        do_issue(5'd3, 3'd1);
        do_issue(5'd4, 3'd2);
        clear_up = 1'b1;
        commit_valid = 1'b1; commit_rd = 5'd3; commit_rob_entry = 3'd7; commit_value = 32'd1;
        issue_valid = 1'b1; issue_rd = 5'd8; issue_rob_entry = 3'd6;
        tick(); idle();
        rs1_id = 5'd3; rs2_id = 5'd4; #1;
        checks++;
        if ({op1_ready, op1_value} !== {1'b1, 32'd1}) begin
            errors++; $display("FAIL clear_x3: got rdy=%b val=%h, want 1/00000001", op1_ready, op1_value);
        end
        checks++;
        if ({op2_ready, op2_value, get_rob_entry2} !== {1'b1, 32'h44, 3'd0}) begin
            errors++; $display("FAIL clear_x4: got rdy=%b val=%h get=%0d, want 1/00000044/0", op2_ready, op2_value, get_rob_entry2);
        end
        rs1_id = 5'd8; #1;
        checks++;
        if ({op1_ready, op1_value, get_rob_entry1} !== {1'b1, 32'd0, 3'd0}) begin
            errors++; $display("FAIL clear_issue_drop: got rdy=%b val=%h get=%0d, want 1/0/0", op1_ready, op1_value, get_rob_entry1);
        end
    endtask

    task automatic test_rdy_low();
        idle(); rdy_in = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd9; issue_rob_entry = 3'd3;
        commit_valid = 1'b1; commit_rd = 5'd10; commit_rob_entry = 3'd0; commit_value = 32'h77;
        tick(); tick(); idle();
        rs1_id = 5'd9; rs2_id = 5'd10; #1;
        checks++;
        if ({op1_ready, op1_value, get_rob_entry1} !== {1'b1, 32'd0, 3'd0}) begin
            errors++; $display("FAIL rdy_low_issue: got rdy=%b val=%h get=%0d, want 1/0/0", op1_ready, op1_value, get_rob_entry1);
        end
        checks++;
        if ({op2_ready, op2_value} !== {1'b1, 32'd0}) begin
            errors++; $display("FAIL rdy_low_commit: got rdy=%b val=%h, want 1/00000000", op2_ready, op2_value);
        end
    endtask

    task automatic test_random();
        logic [32:0] e1, e2;
        for (int n = 0; n < 600; n++) begin
            rdy_in           = ($urandom_range(0, 7) != 0);
            clear_up         = ($urandom_range(0, 31) == 0);
            issue_valid      = $urandom_range(0, 1);
            issue_rd         = 5'($urandom_range(0, 11));
            issue_rob_entry  = RB'($urandom);
            commit_valid     = $urandom_range(0, 1);
            commit_rd        = 5'($urandom_range(0, 11));
            commit_rob_entry = $urandom_range(0, 1) ? m_tag[commit_rd] : RB'($urandom);
            commit_value     = $urandom;
            rs1_id           = 5'($urandom_range(0, 11));
            rs2_id           = ($urandom_range(0, 3) == 0) ? commit_rd : 5'($urandom_range(0, 11));
            ready1           = ($urandom_range(0, 2) == 0);
            ready2           = ($urandom_range(0, 2) == 0);
            value1           = $urandom;
            value2           = $urandom;
            #1;
            e1 = exp_op(rs1_id, ready1, value1);
            e2 = exp_op(rs2_id, ready2, value2);
            checks++;
            if ({op1_ready, op1_value, get_rob_entry1} !== {e1, m_tag[rs1_id]} ||
                (!e1[32] && op1_tag !== m_tag[rs1_id])) begin
                errors++; $display("FAIL rand_op1 n=%0d rs=%0d: got rdy=%b val=%h tag=%0d get=%0d, want rdy=%b val=%h tag=%0d",
                                   n, rs1_id, op1_ready, op1_value, op1_tag, get_rob_entry1, e1[32], e1[31:0], m_tag[rs1_id]);
            end
            checks++;
            if ({op2_ready, op2_value, get_rob_entry2} !== {e2, m_tag[rs2_id]} ||
                (!e2[32] && op2_tag !== m_tag[rs2_id])) begin
                errors++; $display("FAIL rand_op2 n=%0d rs=%0d: got rdy=%b val=%h tag=%0d get=%0d, want rdy=%b val=%h tag=%0d",
                                   n, rs2_id, op2_ready, op2_value, op2_tag, get_rob_entry2, e2[32], e2[31:0], m_tag[rs2_id]);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_x0();
        test_rob_forward();
        test_younger_rename();
        test_commit_bypass();
        test_issue_commit_same();
        test_clear();
        test_rdy_low();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus per-register rename status (busy bit and ROB tag) for the Tomasulo core.
- Register-side end of the ROB issue/commit/operand-query interface:
  - takes rename requests at issue and register writes at commit;
  - resolves source operands for the decoder, either from its own registers or by querying the ROB with the producing entry's tag.

Parameters:
ROB_BIT, 3, width of a ROB entry index (ROB holds 2^ROB_BIT entries)
REG_NUM, 32, number of architectural registers (x0 hard-wired zero)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous reset, active-low
rdy_in  input  1  global ready; state frozen when low
clear_up  input  1  mispredict flush from ROB
issue_valid  input  1  rename request from ROB issue
issue_rd  input  5  destination register being renamed
issue_rob_entry  input  ROB_BIT  ROB entry producing issue_rd
commit_valid  input  1  ROB commit with register write
commit_rd  input  5  committed destination register
commit_rob_entry  input  ROB_BIT  ROB entry being committed
commit_value  input  32  committed result
rs1_id  input  5  decoder source 1 register
rs2_id  input  5  decoder source 2 register
op1_ready  output  1  source 1 value available
op1_value  output  32  source 1 value (0 when not ready)
op1_tag  output  ROB_BIT  producing ROB entry for source 1 (valid when op1_ready=0)
op2_ready  output  1  same, source 2
op2_value  output  32  same, source 2
op2_tag  output  ROB_BIT  same, source 2
get_rob_entry1  output  ROB_BIT  ROB query index for source 1 (= tag of rs1_id)
get_rob_entry2  output  ROB_BIT  ROB query index for source 2
ready1  input  1  ROB: entry get_rob_entry1 has its value (includes same-cycle broadcast)
value1  input  32  ROB value for get_rob_entry1
ready2  input  1  same, entry 2
value2  input  32  same, entry 2

Behaviour:
- State per register: regs[31:0], busy, tag[ROB_BIT-1:0].
- Reset (rst_in=0, async):
  - all regs, busy and tag cleared to 0;
  - outputs settle to op*_ready=1, op*_value=0, op*_tag=0, get_rob_entry*=0.
- rdy_in=0: no state change. Combinational outputs still track inputs.
- x0:
  - never written, never marked busy;
  - reads always give ready=1, value=0.
  - Issue/commit with rd=0 is ignored.
- Operand resolution (combinational, zero latency), per source s, in priority order:
  1. s==0 -> ready, value 0.
  2. !busy[s] -> ready, regs[s].
  3. commit_valid && commit_rd==s && tag[s]==commit_rob_entry -> ready, commit_value (commit bypass).
  4. ready_k from ROB -> ready, value_k.
  5. otherwise -> ready=0, value=0, tag=tag[s].
- get_rob_entry_k = tag[rs_k] at all times.
- Lookup uses pre-issue state: a same-cycle issue to rs does not affect that cycle's operands (e.g. addi x1,x1,1 reads the old x1 status).
- Commit, on the clock edge:
  - regs[commit_rd] <= commit_value;
  - busy cleared only if tag[commit_rd]==commit_rob_entry, so a younger rename stays busy.
- Issue, on the clock edge: busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_entry.
- Issue and commit to the same rd in one cycle:
  - value written;
  - busy=1 and tag=issue_rob_entry (issue wins).
- clear_up (with rdy_in=1):
  - all busy cleared, tags to 0;
  - same-cycle commit value is still written;
  - same-cycle issue is discarded.
- No full/empty condition. Tag width wraps naturally. Tag uniqueness is guaranteed by the ROB.

Test Plan:
- Reset -> every register read returns ready=1, value 0. rs1_id=0 after commit_rd=0 with value 5 -> still 0.
- Issue x5 tag 3. Next cycle read rs1=5 with ready1=0 -> op1_ready=0, op1_tag=3, get_rob_entry1=3. Assert ready1=1, value1=0x1234 -> op1_ready=1, value 0x1234.
- Issue x5 tag 2, then x5 tag 4. Commit entry 2 value 7 -> regs[5]=7, busy stays, tag=4, read not ready.
- Same cycle: commit x6 entry 1 value 9, rs2=6, x6 tag=1 -> op2_ready=1, value 9 via bypass. Next cycle: busy cleared, read gives 9.
- Same cycle: issue x7 tag 5 and commit x7 (old tag 5? no: tag 0, entry 0) value 0xAA -> regs[7]=0xAA, busy=1, tag=5.
- Busy x3, x4. Pulse clear_up with commit x3 value 1 -> x3=1 and x4 old value, both ready. rdy_in=0 during an issue -> no busy change.
